// File: rtl/apa102_in.sv
// APA102 receiver: frames start/LED/end frames from an external clock/data pair
// and unpacks 24-bit pixel payloads into sequential 16-bit memory writes.
// Optional feature macro: APA102_IN_BRIGHTNESS_EN (captures the 5-bit global brightness).
module apa102_in #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_apa_clock_in,
    input  logic                         i_apa_data_in,
    input  logic [ADDRESS_BUS_WIDTH-1:0] i_start_address,
    input  logic [15:0]                  i_max_words,
    output logic [ADDRESS_BUS_WIDTH-1:0] o_write_address,
    output logic [15:0]                  o_write_data,
    output logic                         o_write_strobe,
    output logic                         o_packet_done,
    output logic [15:0]                  o_pixel_count,
    output logic                         o_header_error,
    output logic                         o_overflow,
    output logic [4:0]                   o_brightness
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {HUNT, FRAME, FLUSH} state_t;

    state_t                       r_state;
    logic [1:0]                   r_clk_sync;
    logic [1:0]                   r_dat_sync;
    logic                         r_clk_hist;
    logic [5:0]                   r_zero_cnt;
    logic [30:0]                  r_frame;
    logic [4:0]                   r_bit_cnt;
    logic [TW-1:0]                r_timeout;
    logic [7:0]                   r_residual;
    logic                         r_res_valid;
    logic                         r_pend_valid;
    logic [15:0]                  r_pend_data;
    logic [ADDRESS_BUS_WIDTH-1:0] r_start_addr;
    logic [15:0]                  r_max_words;
    logic [15:0]                  r_word_idx;
    logic [15:0]                  r_pix_cnt;

    logic                         w_rise;
    logic                         w_bit;
    logic [31:0]                  w_frame_next;
    logic                         w_last_bit;
    logic                         w_is_end;
    logic                         w_is_start;
    logic                         w_led_accept;
    logic                         w_wr_req;
    logic [15:0]                  w_wr_data;

    // Both pins are asynchronous: two sync stages, plus a history flop on the clock for edge detect.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clk_sync <= 2'b00;
            r_dat_sync <= 2'b00;
            r_clk_hist <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_apa_clock_in};
            r_dat_sync <= {r_dat_sync[0], i_apa_data_in};
            r_clk_hist <= r_clk_sync[1];
        end
    end

    assign w_rise       = r_clk_sync[1] & ~r_clk_hist;
    assign w_bit        = r_dat_sync[1];
    assign w_frame_next = {r_frame, w_bit};
    assign w_last_bit   = (r_state == FRAME) && w_rise && (r_bit_cnt == 5'd31);
    assign w_is_end     = &w_frame_next;
    assign w_is_start   = ~|w_frame_next;
    assign w_led_accept = w_last_bit && !w_is_end && (w_frame_next[31:29] == 3'b111);

    // A queued second word always wins; it can never coincide with a new LED frame or a flush.
    always_comb begin
        w_wr_req  = 1'b0;
        w_wr_data = 16'h0000;
        if (r_pend_valid) begin
            w_wr_req  = 1'b1;
            w_wr_data = r_pend_data;
        end else if (w_led_accept) begin
            w_wr_req  = 1'b1;
            w_wr_data = r_res_valid ? {r_residual, w_frame_next[23:16]} : w_frame_next[23:8];
        end else if ((r_state == FLUSH) && r_res_valid) begin
            w_wr_req  = 1'b1;
            w_wr_data = {r_residual, 8'h00};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= HUNT;
            r_zero_cnt      <= 6'd0;
            r_frame         <= 31'd0;
            r_bit_cnt       <= 5'd0;
            r_timeout       <= '0;
            r_residual      <= 8'h00;
            r_res_valid     <= 1'b0;
            r_pend_valid    <= 1'b0;
            r_pend_data     <= 16'h0000;
            r_start_addr    <= '0;
            r_max_words     <= 16'h0000;
            r_word_idx      <= 16'h0000;
            r_pix_cnt       <= 16'h0000;
            o_write_address <= '0;
            o_write_data    <= 16'h0000;
            o_write_strobe  <= 1'b0;
            o_packet_done   <= 1'b0;
            o_pixel_count   <= 16'h0000;
            o_header_error  <= 1'b0;
            o_overflow      <= 1'b0;
        end else begin
            o_write_strobe <= 1'b0;
            o_packet_done  <= 1'b0;
            o_header_error <= 1'b0;
            r_pend_valid   <= 1'b0;

            if (w_wr_req) begin
                if (r_word_idx != r_max_words) begin
                    o_write_strobe  <= 1'b1;
                    o_write_address <= r_start_addr + ADDRESS_BUS_WIDTH'(r_word_idx);
                    o_write_data    <= w_wr_data;
                    r_word_idx      <= r_word_idx + 16'd1;
                end else begin
                    o_overflow <= 1'b1;
                end
            end

            case (r_state)
                HUNT: begin
                    if (w_rise) begin
                        if (w_bit) begin
                            r_zero_cnt <= 6'd0;
                        end else if (r_zero_cnt == 6'd31) begin
                            r_zero_cnt   <= 6'd0;
                            r_start_addr <= i_start_address;
                            r_max_words  <= i_max_words;
                            r_word_idx   <= 16'h0000;
                            r_res_valid  <= 1'b0;
                            r_pix_cnt    <= 16'h0000;
                            o_overflow   <= 1'b0;
                            r_bit_cnt    <= 5'd0;
                            r_timeout    <= '0;
                            r_state      <= FRAME;
                        end else begin
                            r_zero_cnt <= r_zero_cnt + 6'd1;
                        end
                    end
                end

                FRAME: begin
                    if (w_rise) begin
                        r_timeout <= '0;
                        r_frame   <= w_frame_next[30:0];
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd31) begin
                            if (w_is_end) begin
                                r_state <= FLUSH;
                            end else if (w_is_start) begin
                                // Restart inside a packet: report it, then begin a fresh packet.
                                o_header_error <= 1'b1;
                                r_start_addr   <= i_start_address;
                                r_max_words    <= i_max_words;
                                r_word_idx     <= 16'h0000;
                                r_res_valid    <= 1'b0;
                                r_pix_cnt      <= 16'h0000;
                                o_overflow     <= 1'b0;
                            end else if (w_led_accept) begin
                                r_pix_cnt <= r_pix_cnt + 16'd1;
                                if (r_res_valid) begin
                                    r_res_valid  <= 1'b0;
                                    r_pend_valid <= 1'b1;
                                    r_pend_data  <= w_frame_next[15:0];
                                end else begin
                                    r_residual  <= w_frame_next[7:0];
                                    r_res_valid <= 1'b1;
                                end
                            end else begin
                                o_header_error <= 1'b1;
                                r_zero_cnt     <= 6'd0;
                                r_state        <= HUNT;
                            end
                        end
                    end else if (r_timeout == TW'(TIMEOUT_CYCLES - 1)) begin
                        o_header_error <= 1'b1;
                        r_zero_cnt     <= 6'd0;
                        r_state        <= HUNT;
                    end else begin
                        r_timeout <= r_timeout + TW'(1);
                    end
                end

                FLUSH: begin
                    // With a pending half word, spend one cycle writing it before signalling done.
                    if (r_res_valid) begin
                        r_res_valid <= 1'b0;
                    end else begin
                        o_packet_done <= 1'b1;
                        o_pixel_count <= r_pix_cnt;
                        r_zero_cnt    <= 6'd0;
                        r_state       <= HUNT;
                    end
                end

                default: begin
                    r_state <= HUNT;
                end
            endcase
        end
    end

`ifdef APA102_IN_BRIGHTNESS_EN
    logic [4:0] r_brightness;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_brightness <= 5'd0;
        end else if (w_led_accept) begin
            r_brightness <= w_frame_next[28:24];
        end
    end

    assign o_brightness = r_brightness;
`else
    assign o_brightness = 5'b11111;
`endif

endmodule

// File: tb/tb_apa102_in.sv
// Directed self-checking bench for apa102_in: a bitstream-level model predicts
// every write, and a monitor checks each write strobe against it.
module tb_apa102_in;

    localparam int AW      = 16;
    localparam int TIMEOUT = 4096;

`ifdef APA102_IN_BRIGHTNESS_EN
    localparam logic [4:0] BR_IDLE = 5'h00;
    localparam logic [4:0] BR_E5   = 5'h05;
`else
    localparam logic [4:0] BR_IDLE = 5'h1F;
    localparam logic [4:0] BR_E5   = 5'h1F;
`endif

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          apaClk    = 1'b0;
    logic          apaData   = 1'b0;
    logic [AW-1:0] startAddr = '0;
    logic [15:0]   maxWords  = 16'h0;

    logic [AW-1:0] writeAddress;
    logic [15:0]   writeData;
    logic          writeStrobe;
    logic          packetDone;
    logic [15:0]   pixelCount;
    logic          headerError;
    logic          overflowFlag;
    logic [4:0]    brightness;

    int totalCount = 0;
    int passCount  = 0;
    int hdrCount   = 0;
    int doneCount  = 0;
    int expHdr     = 0;
    int expDone    = 0;
    logic [15:0] lastPix = 16'h0;

    logic [31:0] ledFrames[$];
    logic [15:0] expAddrQ[$];
    logic [15:0] expDataQ[$];
    logic [15:0] capAddr[$];
    logic [15:0] capData[$];
    bit          expOvf;

    apa102_in #(
        .ADDRESS_BUS_WIDTH(AW),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_apa_clock_in(apaClk),
        .i_apa_data_in(apaData),
        .i_start_address(startAddr),
        .i_max_words(maxWords),
        .o_write_address(writeAddress),
        .o_write_data(writeData),
        .o_write_strobe(writeStrobe),
        .o_packet_done(packetDone),
        .o_pixel_count(pixelCount),
        .o_header_error(headerError),
        .o_overflow(overflowFlag),
        .o_brightness(brightness)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Every write strobe is matched against the head of the predicted write queue.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (writeStrobe) begin
                capAddr.push_back(writeAddress);
                capData.push_back(writeData);
                checkOutput("write expected by model", 32'(expAddrQ.size() > 0), 32'd1);
                if (expAddrQ.size() > 0) begin
                    checkOutput("write_address", 32'(writeAddress), 32'(expAddrQ.pop_front()));
                    checkOutput("write_data", 32'(writeData), 32'(expDataQ.pop_front()));
                end
            end
            if (headerError) hdrCount++;
            if (packetDone) begin
                doneCount++;
                lastPix = pixelCount;
            end
        end
    end

    // Model: concatenate all 24-bit payloads into one bitstream, cut into 16-bit words, zero-pad the tail.
    task automatic buildExpected(input logic [15:0] startA, input logic [15:0] maxW);
        bit          bits[$];
        logic [15:0] words[$];
        logic [15:0] w;
        foreach (ledFrames[f])
            for (int b = 23; b >= 0; b--) bits.push_back(ledFrames[f][b]);
        while (bits.size() > 0) begin
            w = 16'h0;
            for (int k = 0; k < 16; k++) w = {w[14:0], (bits.size() > 0) ? bits.pop_front() : 1'b0};
            words.push_back(w);
        end
        expOvf = (words.size() > int'(maxW));
        for (int i = 0; i < words.size(); i++) begin
            if (i < int'(maxW)) begin
                expAddrQ.push_back(startA + 16'(i));
                expDataQ.push_back(words[i]);
            end
        end
    endtask

    task automatic sendBit(input logic b);
        @(negedge clk);
        apaClk  = 1'b0;
        apaData = b;
        repeat (5) @(negedge clk);
        apaClk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic applyBits(input logic [31:0] frame, input int n);
        for (int i = 31; i > 31 - n; i--) sendBit(frame[i]);
    endtask

    task automatic applyStimulus(input logic [31:0] frame);
        applyBits(frame, 32);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        apaClk = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic runPacket(input logic [15:0] startA, input logic [15:0] maxW);
        capAddr.delete();
        capData.delete();
        buildExpected(startA, maxW);
        startAddr = startA;
        maxWords  = maxW;
        applyStimulus(32'h0000_0000);
        foreach (ledFrames[f]) applyStimulus(ledFrames[f]);
        applyStimulus(32'hFFFF_FFFF);
        idle(20);
        expDone++;
        checkOutput("writes outstanding", 32'(expAddrQ.size()), 32'd0);
        checkOutput("packet_done count", 32'(doneCount), 32'(expDone));
        checkOutput("pixel_count", 32'(lastPix), 32'(ledFrames.size()));
        checkOutput("overflow", 32'(overflowFlag), 32'(expOvf));
        checkOutput("header_error count", 32'(hdrCount), 32'(expHdr));
    endtask

    initial begin
        int bad;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: everything quiet.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (writeStrobe || packetDone || headerError || overflowFlag ||
                (writeAddress != '0) || (writeData != 16'h0) || (pixelCount != 16'h0) ||
                (brightness != BR_IDLE)) bad++;
        end
        checkOutput("reset idle outputs", 32'(bad), 32'd0);

        // Two pixels, three whole words.
        ledFrames = '{32'hFF11_2233, 32'hFF44_5566};
        runPacket(16'h0100, 16'hFFFF);
        checkOutput("p1 word0", 32'(capData.size() > 0 ? capData[0] : 16'h0), 32'h1122);
        checkOutput("p1 word2", 32'(capData.size() > 2 ? capData[2] : 16'h0), 32'h5566);
        checkOutput("p1 addr2", 32'(capAddr.size() > 2 ? capAddr[2] : 16'h0), 32'h0102);
        checkOutput("p1 pixel literal", 32'(lastPix), 32'd2);
        checkOutput("p1 brightness", 32'(brightness), 32'h1F);

        // One pixel leaves a half word that the flush pads.
        ledFrames = '{32'hE5AA_BBCC};
        runPacket(16'h0200, 16'hFFFF);
        checkOutput("p2 word1 padded", 32'(capData.size() > 1 ? capData[1] : 16'h0), 32'hCC00);
        checkOutput("p2 addr1", 32'(capAddr.size() > 1 ? capAddr[1] : 16'h0), 32'h0201);
        checkOutput("p2 brightness", 32'(brightness), 32'(BR_E5));

        // Bad header after a start frame.
        capData.delete();
        startAddr = 16'h0300;
        applyStimulus(32'h0000_0000);
        applyStimulus(32'h5F00_0000);
        idle(20);
        expHdr++;
        checkOutput("bad header error", 32'(hdrCount), 32'(expHdr));
        checkOutput("bad header no writes", 32'(capData.size()), 32'd0);
        checkOutput("bad header no done", 32'(doneCount), 32'(expDone));
        ledFrames = '{32'hFF01_0203};
        runPacket(16'h0300, 16'hFFFF);

        // Word limit reached mid-packet.
        ledFrames = '{32'hFF11_2233, 32'hFF44_5566};
        runPacket(16'h0400, 16'd2);
        checkOutput("limit write count", 32'(capData.size()), 32'd2);
        checkOutput("limit overflow literal", 32'(overflowFlag), 32'd1);
        applyStimulus(32'h0000_0000);
        idle(10);
        checkOutput("overflow cleared by start", 32'(overflowFlag), 32'd0);
        applyStimulus(32'hFFFF_FFFF);
        idle(20);
        expDone++;
        checkOutput("empty packet done", 32'(doneCount), 32'(expDone));
        checkOutput("empty packet pixels", 32'(lastPix), 32'd0);

        // Clock stalls mid-frame.
        capData.delete();
        applyStimulus(32'h0000_0000);
        applyBits(32'hFF11_2233, 10);
        idle(TIMEOUT + 50);
        expHdr++;
        checkOutput("timeout error", 32'(hdrCount), 32'(expHdr));
        checkOutput("timeout no writes", 32'(capData.size()), 32'd0);
        checkOutput("timeout no done", 32'(doneCount), 32'(expDone));

        // Reset in the middle of a frame, with stale nonzero outputs beforehand.
        ledFrames = '{32'hFF11_2233, 32'hFF44_5566};
        runPacket(16'h0500, 16'd1);
        applyStimulus(32'h0000_0000);
        applyBits(32'hFF11_2233, 10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst write_strobe", 32'(writeStrobe), 32'd0);
        checkOutput("rst write_address", 32'(writeAddress), 32'd0);
        checkOutput("rst write_data", 32'(writeData), 32'd0);
        checkOutput("rst pixel_count", 32'(pixelCount), 32'd0);
        checkOutput("rst overflow", 32'(overflowFlag), 32'd0);
        checkOutput("rst brightness", 32'(brightness), 32'(BR_IDLE));
        idle(5);
        @(negedge clk);
        rst = 1'b0;
        idle(50);
        checkOutput("rst no done", 32'(doneCount), 32'(expDone));
        checkOutput("rst no header error", 32'(hdrCount), 32'(expHdr));

        // Normal operation after reset.
        ledFrames = '{32'hFFA1_B2C3};
        runPacket(16'h0600, 16'hFFFF);
        checkOutput("post-rst word0", 32'(capData.size() > 0 ? capData[0] : 16'h0), 32'hA1B2);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/apa102_in.md
# apa102_in

Receive-side counterpart of the APA102 pixel output engine: samples an external APA102 clock/data pair, frames start, LED and end frames, and unpacks the 24-bit BGR payloads into a continuous stream of 16-bit words written to sequential memory addresses. Used for loop-back verification of the LED output path and for capturing pixel streams from an upstream controller into the shared frame buffer.

## Interface

- ADDRESS_BUS_WIDTH, 16, width of `write_address`.
- TIMEOUT_CYCLES, 4096, `clk` cycles without an APA102 clock rising edge before an in-progress packet is aborted.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- apa_clock_in  in  1  APA102 clock pin, asynchronous to `clk`.
- apa_data_in  in  1  APA102 data pin, asynchronous to `clk`.
- start_address  in  ADDRESS_BUS_WIDTH  first write address; latched when a start frame completes.
- max_words  in  16  word limit per packet; latched with `start_address`.
- write_address  out  ADDRESS_BUS_WIDTH  address of current word.
- write_data  out  16  assembled word.
- write_strobe  out  1  one-cycle write pulse; no backpressure.
- packet_done  out  1  one-cycle pulse after end frame processed.
- pixel_count  out  16  LED frames in last packet; updated with `packet_done`.
- header_error  out  1  one-cycle pulse on bad header, restart or timeout.
- overflow  out  1  sticky: words dropped at `max_words`; cleared at next start frame.
- brightness  out  5  global brightness of last accepted LED frame.

## Operation

- Both pins pass through a 2-flop synchronizer plus one history flop; a rising edge is sync==1 & hist==0; data bit sampled from synchronized data on that cycle. Bits are MSB first.
- States: HUNT, FRAME, FLUSH.
- HUNT: 6-bit zero-run counter; a 1 bit clears it; on 32nd consecutive 0 bit -> latch `start_address`/`max_words`, clear word counter, residual, pixel counter, `overflow`; go FRAME.
- FRAME: shift 32 bits into frame register. On the 32nd bit classify:
  - all ones: end frame -> FLUSH.
  - all zeros: new start frame; pulse `header_error`, discard residual, re-latch as in HUNT, stay FRAME.
  - bits[31:29]==3'b111: LED frame; pixel_count+1; append bits[23:0] to word assembler.
  - otherwise: pulse `header_error`, discard packet (no `packet_done`), go HUNT.
- Word assembler: residual register holds 0 or 8 pending bits. 0 pending + 24 -> write bits[23:8], keep 8. 8 pending + 24 -> write {residual, bits[23:16]}, then bits[15:0], residual empty.
- FLUSH: if 8 bits pending, write {residual, 8'h00}; pulse `packet_done`; go HUNT.
- Each write: `write_address` = latched start + word index; index increments per issued word. Once index == max_words, writes suppressed, `overflow` set, decoding continues.
- Timeout: in FRAME, counter reloads on every rising edge; reaching TIMEOUT_CYCLES -> pulse `header_error`, go HUNT. Not active in HUNT.

## Timing

- Reset: all outputs 0, state HUNT, counters and residual 0.
- Pin-to-edge-detect latency: 3 `clk` cycles. APA102 clock high and low phases each ≥ 4 `clk`; data stable ≥ 3 `clk` before and after its rising edge.
- First write of a frame: `write_strobe` on cycle after the 32nd-bit edge is detected; a second word in the same frame on the following cycle. `write_address`/`write_data` valid only while `write_strobe` is high.
- `packet_done` asserted 1 cycle after end frame detection, or 1 cycle after flush write.
- `rst` mid-packet: immediate return to HUNT; partial words discarded; no `packet_done`.

## Configuration

- APA102_IN_BRIGHTNESS_EN defined: `brightness` loads bits[28:24] of every accepted LED frame.
- Undefined: `brightness` held at 5'b11111; no capture register synthesized. Decoding unaffected.

## Test plan

- Reset, no pin activity -> all outputs 0 for 100 cycles; state remains HUNT.
- 32 zero bits, LED frames 0xFF112233 and 0xFF445566, 32 one bits, start_address 0x0100 -> writes 0x1122@0x0100, 0x3344@0x0101, 0x5566@0x0102; packet_done, pixel_count=2.
- Single LED frame 0xE5AABBCC then end frame -> 0xAABB@start, 0xCC00@start+1; with APA102_IN_BRIGHTNESS_EN brightness=5'h05, without brightness=5'h1F.
- Start frame then 0x5F000000 -> header_error pulse, no write_strobe, subsequent valid packet decoded normally.
- max_words=2, two pixels -> exactly 2 writes, overflow=1, packet_done still pulses; next start frame clears overflow.
- Clock stops after 10 bits of an LED frame for TIMEOUT_CYCLES -> header_error, no writes; separately, assert rst mid-frame -> outputs 0 immediately, no packet_done.
